pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage.sv | 115 +++++++++++
 tb/tb_pipe_skid_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage with registered handshakes,
// flush, and a saturating back-pressure statistics counter.
module pipe_skid_stage #(
   parameter int unsigned       DATA_W    = 64,
   parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
   parameter int unsigned       CNT_W     = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              flush_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   input  logic              clr_cnt_i,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e            state_q;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;
   logic              vld_q;
   logic              rdy_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              accept;
   logic              consume;

   assign accept  = in_valid_i & rdy_q;
   assign consume = vld_q & out_ready_i;

   assign in_ready_o  = rdy_q;
   assign out_valid_o = vld_q;
   assign out_data_o  = main_q;
   assign stall_cnt_o = cnt_q;

   // Handshake outputs are registered alongside the state so in_ready_o
   // never depends combinationally on out_ready_i.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= EMPTY;
         main_q  <= NOP_VALUE;
         skid_q  <= '0;
         vld_q   <= 1'b0;
         rdy_q   <= 1'b1;
      end else if (flush_i) begin
         state_q <= EMPTY;
         main_q  <= NOP_VALUE;
         vld_q   <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_q <= ONE;
                  main_q  <= in_data_i;
                  vld_q   <= 1'b1;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  main_q <= in_data_i;
               end else if (accept) begin
                  state_q <= TWO;
                  skid_q  <= in_data_i;
                  rdy_q   <= 1'b0;
               end else if (consume) begin
                  state_q <= EMPTY;
                  main_q  <= NOP_VALUE;
                  vld_q   <= 1'b0;
               end
            end
            TWO: begin
               if (consume) begin
                  state_q <= ONE;
                  main_q  <= skid_q;
                  rdy_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= EMPTY;
               main_q  <= NOP_VALUE;
               vld_q   <= 1'b0;
               rdy_q   <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt_i) begin
         cnt_d = '0;
      end else if (vld_q && !out_ready_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus random traffic,
// with a queue scoreboard checked by an independent output monitor.
module tb_pipe_skid_stage;

   localparam logic [63:0] NOP = 64'h0000_0000_0000_DEAD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [63:0] in_data = '0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic        clr = 1'b0;
   logic        in_ready, out_valid;
   logic [63:0] out_data;
   logic [15:0] cnt;
   logic        in_ready2, out_valid2;
   logic [63:0] out_data2;
   logic [1:0]  cnt2;

   int n_chk = 0;
   int n_fail = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   pipe_skid_stage #(.DATA_W(64), .NOP_VALUE(NOP), .CNT_W(16)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_data_i(in_data), .flush_i(flush),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_data_o(out_data), .clr_cnt_i(clr),
      .stall_cnt_o(cnt)
   );

   pipe_skid_stage #(.DATA_W(64), .NOP_VALUE(NOP), .CNT_W(2)) dut2 (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready2),
      .in_data_i(in_data), .flush_i(flush),
      .out_valid_o(out_valid2), .out_ready_i(out_ready),
      .out_data_o(out_data2), .clr_cnt_i(clr),
      .stall_cnt_o(cnt2)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [63:0] d,
                      input logic rdy, input logic fl, input logic cl);
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      flush     = fl;
      clr       = cl;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard fill: accepted payloads queue up, flush drops held ones
   always @(posedge clk) begin
      if (rst_n) begin
         if (flush) exp_q.delete();
         else if (in_valid && in_ready) exp_q.push_back(in_data);
      end
   end

   always @(negedge rst_n) exp_q.delete();

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            if (out_ready) begin
               n_chk++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL mon_extra: got %h expected none",
                           out_data);
               end else begin
                  logic [63:0] e;
                  e = exp_q.pop_front();
                  if (out_data !== e) begin
                     n_fail++;
                     $display("FAIL mon_data: got %h expected %h",
                              out_data, e);
                  end
               end
            end
         end else begin
            n_chk++;
            if (out_data !== NOP) begin
               n_fail++;
               $display("FAIL mon_nop: got %h expected %h",
                        out_data, NOP);
            end
         end
      end
   end

   initial begin
      #12;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_data", out_data, NOP);
      chk("rst_cnt", 64'(cnt), 64'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // streaming
      cyc(1'b1, 64'hA, 1'b1, 1'b0, 1'b0);
      chk("str_a", out_data, 64'hA);
      chk("str_rdy_a", 64'(in_ready), 64'd1);
      cyc(1'b1, 64'hB, 1'b1, 1'b0, 1'b0);
      chk("str_b", out_data, 64'hB);
      chk("str_rdy_b", 64'(in_ready), 64'd1);
      cyc(1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
      chk("str_c", out_data, 64'hC);
      chk("str_rdy_c", 64'(in_ready), 64'd1);
      cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      chk("str_empty", 64'(out_valid), 64'd0);
      chk("str_cnt", 64'(cnt), 64'd0);

      // skid fill and drain
      cyc(1'b1, 64'hA2, 1'b0, 1'b0, 1'b0);
      chk("skid_one", out_data, 64'hA2);
      cyc(1'b1, 64'hB2, 1'b0, 1'b0, 1'b0);
      chk("skid_two_rdy", 64'(in_ready), 64'd0);
      chk("skid_two_data", out_data, 64'hA2);
      cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      chk("skid_b", out_data, 64'hB2);
      chk("skid_rdy_back", 64'(in_ready), 64'd1);
      cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      chk("skid_empty", 64'(out_valid), 64'd0);
      chk("skid_cnt", 64'(cnt), 64'd1);
      cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
      chk("clr_cnt", 64'(cnt), 64'd0);

      // flush from TWO with a pending input, then from ONE with consume
      cyc(1'b1, 64'hD, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 64'hE, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 64'hF, 1'b0, 1'b1, 1'b0);
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_data", out_data, NOP);
      chk("fl_ready", 64'(in_ready), 64'd1);
      cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      chk("fl_stay", 64'(out_valid), 64'd0);
      cyc(1'b1, 64'h6, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 64'h7, 1'b1, 1'b1, 1'b0);
      chk("fl1_valid", 64'(out_valid), 64'd0);
      chk("fl_cnt", 64'(cnt), 64'd2);
      cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);

      // stall counter and saturation
      cyc(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      chk("cnt5", 64'(cnt), 64'd5);
      cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      chk("cnt6", 64'(cnt), 64'd6);
      chk("cnt2_sat", 64'(cnt2), 64'd3);
      cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
      chk("cnt_clr_stall", 64'(cnt), 64'd0);
      chk("cnt2_clr", 64'(cnt2), 64'd0);
      cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

      // async reset while in TWO
      cyc(1'b1, 64'h21, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 64'h22, 1'b0, 1'b0, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      chk("ar_valid", 64'(out_valid), 64'd0);
      chk("ar_ready", 64'(in_ready), 64'd1);
      chk("ar_data", out_data, NOP);
      chk("ar_cnt", 64'(cnt), 64'd0);
      in_valid = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(1'b1, 64'h31, 1'b1, 1'b0, 1'b0);
      chk("ar_p", out_data, 64'h31);
      cyc(1'b1, 64'h32, 1'b1, 1'b0, 1'b0);
      chk("ar_q", out_data, 64'h32);
      cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

      // random valid/ready/flush traffic
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 1)), {$urandom, $urandom},
             1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 15) == 0), 1'b0);
      end
      for (int i = 0; i < 4; i++) cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      chk("drain", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
